// File: rtl/mips_mc_controller_pkg.sv
// -----------------------------------------------------------------------------
// mips_defs
//   Shared definitions for the mini_mips multicycle controller:
//   opcodes, FSM state encodings, ALU operation codes and the mux
//   select codes used for alusrcb and pcsource.
// -----------------------------------------------------------------------------
package mips_defs;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // Controller states; encoding 4'd15 is unused and recovers to FETCH1
  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_e;

  // ALU operation requested from the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_controller.sv
// -----------------------------------------------------------------------------
// mips_mc_controller
//   Moore multicycle control FSM for the 8-bit mini_mips datapath. Each
//   32-bit instruction is fetched as four byte reads, then decoded and
//   sequenced through LB, SB, R-type, BEQ, J or ADDI execution states.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   op        in   opcode from IR[31:26]
//   zero      in   ALU zero flag
//   memread   out  memory read strobe
//   memwrite  out  memory write strobe
//   iord      out  address select: 0 = PC, 1 = ALUOut
//   irwrite   out  one-hot IR byte load enable
//   alusrca   out  ALU A select: 0 = PC, 1 = regA
//   alusrcb   out  ALU B select (see mips_defs SRCB_*)
//   aluop     out  ALU operation (see mips_defs ALUOP_*)
//   pcsource  out  PC mux select (see mips_defs PCSRC_*)
//   pcen      out  PC write enable
//   regwrite  out  register file write enable
//   regdst    out  destination select: 0 = rt, 1 = rd
//   memtoreg  out  writeback select: 0 = ALUOut, 1 = MDR
//   state     out  current state, debug only
// -----------------------------------------------------------------------------
module mips_mc_controller
  import mips_defs::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               zero,
  output logic               memread,
  output logic               memwrite,
  output logic               iord,
  output logic [3:0]         irwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsource,
  output logic               pcen,
  output logic               regwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic [STATE_W-1:0] state
);

  state_e state_q;
  state_e state_d;

  // Decoded (pre-reset-gating) control values
  logic       memread_s;
  logic       memwrite_s;
  logic       iord_s;
  logic [3:0] irwrite_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic [1:0] aluop_s;
  logic [1:0] pcsource_s;
  logic       pcwrite_s;
  logic       pcwritecond_s;
  logic       regwrite_s;
  logic       regdst_s;
  logic       memtoreg_s;

  // State register with synchronous reset to FETCH1
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; op is only consulted in DECODE and MEMADR
  always_comb begin
    state_d = S_FETCH1;
    case (state_q)
      S_FETCH1:  state_d = S_FETCH2;
      S_FETCH2:  state_d = S_FETCH3;
      S_FETCH3:  state_d = S_FETCH4;
      S_FETCH4:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH1;  // unknown opcode behaves as NOP
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LB) begin
          state_d = S_LBRD;
        end else begin
          state_d = S_SBWR;
        end
      end
      S_LBRD:    state_d = S_LBWR;
      S_RTYPEEX: state_d = S_RTYPEWR;
      S_ADDIEX:  state_d = S_ADDIWR;
      S_LBWR, S_SBWR, S_RTYPEWR, S_BEQEX, S_JEX, S_ADDIWR: state_d = S_FETCH1;
      default:   state_d = S_FETCH1;
    endcase
  end

  // Moore output decode from the current state
  always_comb begin
    memread_s     = 1'b0;
    memwrite_s    = 1'b0;
    iord_s        = 1'b0;
    irwrite_s     = 4'b0000;
    alusrca_s     = 1'b0;
    alusrcb_s     = SRCB_REGB;
    aluop_s       = ALUOP_ADD;
    pcsource_s    = PCSRC_ALU;
    pcwrite_s     = 1'b0;
    pcwritecond_s = 1'b0;
    regwrite_s    = 1'b0;
    regdst_s      = 1'b0;
    memtoreg_s    = 1'b0;
    case (state_q)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        // Each fetch cycle loads one IR byte and bumps PC by one
        memread_s = 1'b1;
        alusrcb_s = SRCB_ONE;
        pcwrite_s = 1'b1;
        case (state_q)
          S_FETCH1: irwrite_s = 4'b0001;
          S_FETCH2: irwrite_s = 4'b0010;
          S_FETCH3: irwrite_s = 4'b0100;
          S_FETCH4: irwrite_s = 4'b1000;
          default:  irwrite_s = 4'b0000;
        endcase
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut
        alusrcb_s = SRCB_BRIMM;
      end
      S_MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = SRCB_IMM;
      end
      S_LBRD: begin
        memread_s = 1'b1;
        iord_s    = 1'b1;
      end
      S_LBWR: begin
        regwrite_s = 1'b1;
        memtoreg_s = 1'b1;
      end
      S_SBWR: begin
        memwrite_s = 1'b1;
        iord_s     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca_s = 1'b1;
        aluop_s   = ALUOP_FUNCT;
      end
      S_RTYPEWR: begin
        regwrite_s = 1'b1;
        regdst_s   = 1'b1;
      end
      S_BEQEX: begin
        alusrca_s     = 1'b1;
        aluop_s       = ALUOP_SUB;
        pcwritecond_s = 1'b1;
        pcsource_s    = PCSRC_ALUOUT;
      end
      S_JEX: begin
        pcwrite_s  = 1'b1;
        pcsource_s = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = SRCB_IMM;
      end
      S_ADDIWR: begin
        regwrite_s = 1'b1;
      end
      default: begin
        memread_s = 1'b0;
      end
    endcase
  end

  // Reset gating: while reset is high nothing may strobe, so an instruction
  // interrupted by reset cannot complete a partial register/memory write.
  always_comb begin
    if (reset) begin
      memread  = 1'b0;
      memwrite = 1'b0;
      iord     = 1'b0;
      irwrite  = 4'b0000;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      aluop    = 2'b00;
      pcsource = 2'b00;
      pcen     = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
    end else begin
      memread  = memread_s;
      memwrite = memwrite_s;
      iord     = iord_s;
      irwrite  = irwrite_s;
      alusrca  = alusrca_s;
      alusrcb  = alusrcb_s;
      aluop    = aluop_s;
      pcsource = pcsource_s;
      pcen     = pcwrite_s | (pcwritecond_s & zero);
      regwrite = regwrite_s;
      regdst   = regdst_s;
      memtoreg = memtoreg_s;
    end
  end

  assign state = STATE_W'(state_q);

endmodule
